// File: rtl/conv_window_scheduler_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_sched_pkg : state encoding and sizing helpers for the scheduler  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int calc_ow(input int img_w, input int k, input int s);
    return (img_w - k) / s + 1;
  endfunction

  function automatic int calc_oh(input int img_h, input int k, input int s);
    return (img_h - k) / s + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_scheduler_wrap_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wrap_counter : modulo-N up counter with terminal-count flag           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module wrap_counter
  import conv_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_cout
);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last  = (r_count == W'(N - 1));
  assign o_count = r_count;
  assign o_cout  = w_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_window_scheduler : sequences one KxK convolution pass, producing |
// | ifmap/filter/ofmap addresses, MAC controls and a result handshake.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mac_clr,
  output logic              o_mac_en,
  output logic              o_acc_valid,
  output logic [ADDR_W-1:0] o_ifmap_addr,
  output logic [ADDR_W-1:0] o_filt_addr,
  output logic [ADDR_W-1:0] o_out_addr
);

  localparam int c_OW = calc_ow(IMG_W, K, STRIDE);
  localparam int c_OH = calc_oh(IMG_H, K, STRIDE);
  localparam int c_KW = clog2w(K);
  localparam int c_XW = clog2w(c_OW);
  localparam int c_YW = clog2w(c_OH);

  localparam logic [ADDR_W-1:0] c_S_A  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] c_IW_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_K_A  = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] c_OW_A = ADDR_W'(c_OW);

  state_t            r_state;
  state_t            w_next;
  logic [c_KW-1:0]   r_kc, r_kr;
  logic [c_XW-1:0]   r_ox;
  logic [c_YW-1:0]   r_oy;
  logic              w_kc_cout, w_kr_cout, w_ox_cout, w_oy_cout;
  logic              w_kc_en, w_kr_en, w_ox_en, w_oy_en;
  logic              w_cnt_rst_n;
  logic              w_handshake;
  logic [ADDR_W-1:0] w_row;

  // Entering DONE also clears the counters so IDLE always presents zero addresses.
  assign w_cnt_rst_n = rst & (r_state != ST_DONE);
  assign w_handshake = (r_state == ST_EMIT) & i_out_ready;
  assign w_kc_en     = (r_state == ST_MAC);
  assign w_kr_en     = w_kc_en & w_kc_cout;
  assign w_ox_en     = w_handshake;
  assign w_oy_en     = w_handshake & w_ox_cout;

  wrap_counter #(.N(K))    u_kc (.clk(clk), .rst(w_cnt_rst_n), .i_en(w_kc_en), .o_count(r_kc), .o_cout(w_kc_cout));
  wrap_counter #(.N(K))    u_kr (.clk(clk), .rst(w_cnt_rst_n), .i_en(w_kr_en), .o_count(r_kr), .o_cout(w_kr_cout));
  wrap_counter #(.N(c_OW)) u_ox (.clk(clk), .rst(w_cnt_rst_n), .i_en(w_ox_en), .o_count(r_ox), .o_cout(w_ox_cout));
  wrap_counter #(.N(c_OH)) u_oy (.clk(clk), .rst(w_cnt_rst_n), .i_en(w_oy_en), .o_count(r_oy), .o_cout(w_oy_cout));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_busy      = (r_state != ST_IDLE);
    o_done      = 1'b0;
    o_mac_clr   = 1'b0;
    o_mac_en    = 1'b0;
    o_acc_valid = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_CLEAR;
      ST_CLEAR: begin
        o_mac_clr = 1'b1;
        w_next    = ST_MAC;
      end
      ST_MAC: begin
        o_mac_en = 1'b1;
        if (w_kr_cout && w_kc_cout) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        o_acc_valid = 1'b1;
        if (i_out_ready) w_next = (w_ox_cout && w_oy_cout) ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_row        = ADDR_W'(r_oy) * c_S_A + ADDR_W'(r_kr);
  assign o_ifmap_addr = w_row * c_IW_A + ADDR_W'(r_ox) * c_S_A + ADDR_W'(r_kc);
  assign o_filt_addr  = ADDR_W'(r_kr) * c_K_A + ADDR_W'(r_kc);
  assign o_out_addr   = ADDR_W'(r_oy) * c_OW_A + ADDR_W'(r_ox);

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_conv_window_scheduler : three scheduler geometries checked cycle   |
// | by cycle against a nested-loop model of the convolution pass. Rev 1.0 |
// +-----------------------------------------------------------------------+
module tb_conv_window_scheduler;

  logic        clk;
  logic        rst;
  logic        start [3];
  logic        ready [3];
  logic        busy  [3];
  logic        done  [3];
  logic        clr   [3];
  logic        en    [3];
  logic        av    [3];
  logic [15:0] ifa   [3];
  logic [15:0] fa    [3];
  logic [15:0] oa    [3];

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;

  int pw [3] = '{4, 5, 2};
  int ph [3] = '{4, 5, 2};
  int pk [3] = '{3, 3, 1};
  int ps [3] = '{1, 2, 1};

  typedef struct {
    bit       rst;
    bit       st;
    bit       rd;
    bit [4:0] ctrl;
    int       ia;
    int       fa;
    int       oa;
  } vec_t;
  vec_t tbl [20];

  conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .ADDR_W(16)) u_a (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_out_ready(ready[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_mac_clr(clr[0]), .o_mac_en(en[0]),
    .o_acc_valid(av[0]), .o_ifmap_addr(ifa[0]), .o_filt_addr(fa[0]), .o_out_addr(oa[0]));

  conv_window_scheduler #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .ADDR_W(16)) u_b (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_out_ready(ready[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_mac_clr(clr[1]), .o_mac_en(en[1]),
    .o_acc_valid(av[1]), .o_ifmap_addr(ifa[1]), .o_filt_addr(fa[1]), .o_out_addr(oa[1]));

  conv_window_scheduler #(.IMG_W(2), .IMG_H(2), .K(1), .STRIDE(1), .ADDR_W(16)) u_c (
    .clk(clk), .rst(rst), .i_start(start[2]), .i_out_ready(ready[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_mac_clr(clr[2]), .o_mac_en(en[2]),
    .o_acc_valid(av[2]), .o_ifmap_addr(ifa[2]), .o_filt_addr(fa[2]), .o_out_addr(oa[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void chk(input int d, input string tag, input string f,
                              input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL dut%0d %s.%s cyc=%0d got=%0h exp=%0h", d, tag, f, cyc, act, exp);
    end
  endfunction

  // ctrl bit order: {busy, done, mac_clr, mac_en, acc_valid}
  function automatic void exp_out(input int d, input string tag, input bit [4:0] ctrl,
                                  input int ia, input int fx, input int ox);
    chk(d, tag, "ctrl", int'({busy[d], done[d], clr[d], en[d], av[d]}), int'(ctrl));
    chk(d, tag, "ifmap_addr", int'(ifa[d]), ia);
    chk(d, tag, "filt_addr", int'(fa[d]), fx);
    chk(d, tag, "out_addr", int'(oa[d]), ox);
  endfunction

  task automatic drive_ready(input int d, input int bp);
    ready[d] = (bp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // bp: 0 ready always high, 1 random stalls/noise, 2 five-cycle stall in first EMIT
  task automatic run_pass(input int d, input int bp, input bit hold);
    int w, h, k, s, ow, oh, stalls, base;
    bit first;
    w = pw[d]; h = ph[d]; k = pk[d]; s = ps[d];
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    first = 1'b1;
    drive_ready(d, bp);
    exp_out(d, "idle", 5'b00000, 0, 0, 0);
    start[d] = 1'b1;
    step();
    if (!hold) start[d] = 1'b0;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        base = oy * s * w + ox * s;
        drive_ready(d, bp);
        exp_out(d, "clear", 5'b10100, base, 0, oy * ow + ox);
        step();
        for (int kr = 0; kr < k; kr++) begin
          for (int kc = 0; kc < k; kc++) begin
            drive_ready(d, bp);
            exp_out(d, "mac", 5'b10010, base + kr * w + kc, kr * k + kc, oy * ow + ox);
            step();
          end
        end
        stalls = (bp == 2 && first) ? 5 : ((bp == 1) ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i <= stalls; i++) begin
          ready[d] = (i == stalls);
          exp_out(d, "emit", 5'b10001, base, 0, oy * ow + ox);
          step();
        end
        first = 1'b0;
      end
    end
    drive_ready(d, bp);
    exp_out(d, "done", 5'b11000, 0, 0, 0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      ready[d] = 1'b0;
    end

    // Window 1 of the 4x4 pass with a stall, then reset (with start) mid-MAC of window 2.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'b00000, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'b10100, 0, 0, 0};
    for (int i = 0; i < 9; i++)
      tbl[2 + i] = '{1'b1, 1'b0, 1'(i % 2), 5'b10010, (i / 3) * 4 + i % 3, i, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b10001, 0, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'b10001, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 5'b10001, 0, 0, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 5'b10100, 1, 0, 1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 5'b10010, 1, 0, 1};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 5'b10010, 2, 1, 1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 5'b10010, 3, 2, 1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 5'b00000, 0, 0, 0};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 5'b00000, 0, 0, 0};

    repeat (3) step();
    for (int d = 0; d < 3; d++) exp_out(d, "reset", 5'b00000, 0, 0, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      rst      = tbl[i].rst;
      start[0] = tbl[i].st;
      ready[0] = tbl[i].rd;
      exp_out(0, "tbl", tbl[i].ctrl, tbl[i].ia, tbl[i].fa, tbl[i].oa);
      step();
    end
    rst = 1'b1;

    run_pass(0, 0, 1'b0);
    run_pass(0, 2, 1'b0);
    run_pass(0, 1, 1'b0);
    run_pass(1, 0, 1'b0);
    run_pass(1, 1, 1'b0);
    run_pass(2, 0, 1'b0);
    run_pass(2, 1, 1'b0);

    // start held high across two passes: ignored mid-pass, relaunches straight from IDLE.
    run_pass(0, 0, 1'b1);
    run_pass(0, 1, 1'b1);
    start[0] = 1'b0;
    exp_out(0, "idle_after_hold", 5'b00000, 0, 0, 0);
    step();
    exp_out(0, "idle_stays", 5'b00000, 0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      run_pass(int'($urandom_range(0, 2)), 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
